// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: streams the first N Fibonacci terms (1, 1, 2, 3, 5, ...) as
// 16-bit values over a valid/ready output port, one job at a time.
//
// Handshake: a request is accepted on any cycle where req_valid && req_ready.
// An output beat is transferred on any cycle where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_data/out_last/out_ovf
// are held stable until the transfer happens.
//
// The term pair (a,b) holds the current and next term. out_data shows a.
// The pair advances only on a transfer, and the sum is formed at 17 bits so
// the carry out can be used to flag that the true value left 16-bit range.
// dbg_state_o exposes the FSM state for observation.
module fib_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_count,
  output logic             req_ready,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_last,
  output logic             out_ovf,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // terms still to be transferred
  logic [15:0]      a_q, a_d;         // current term (truncated)
  logic [15:0]      b_q, b_d;         // next term (truncated)
  logic             ovf_q, ovf_d;     // current or earlier term >= 2^16
  logic             b_ovf_q, b_ovf_d; // next term's true value >= 2^16

  logic             accept;
  logic             xfer;
  logic             last_beat;
  logic [16:0]      sum;

  // Handshake qualifiers and the 17-bit adder for the next pair value.
  assign accept    = (state_q == S_IDLE) && req_valid;
  assign xfer      = (state_q == S_RUN) && out_ready;
  assign last_beat = (cnt_q == CNT_ONE);
  assign sum       = {1'b0, a_q} + {1'b0, b_q};

  // State and datapath registers; reset discards any stalled beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      a_q     <= 16'd1;
      b_q     <= 16'd1;
      ovf_q   <= 1'b0;
      b_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ovf_q   <= ovf_d;
      b_ovf_q <= b_ovf_d;
    end
  end

  // Next-state logic: a final-beat transfer wins over a same-cycle abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_count != CNT_ZERO) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (xfer && last_beat) begin
          state_d = S_DONE;
        end else if (abort) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath next values: load on acceptance, advance the pair on transfer.
  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    ovf_d   = ovf_q;
    b_ovf_d = b_ovf_q;
    if (accept) begin
      cnt_d   = req_count;
      a_d     = 16'd1;
      b_d     = 16'd1;
      ovf_d   = 1'b0;
      b_ovf_d = 1'b0;
    end else if (xfer) begin
      cnt_d   = cnt_q - CNT_ONE;
      a_d     = b_q;
      b_d     = sum[15:0];
      // The term moving into a inherits b's flag; b picks up a new carry.
      ovf_d   = ovf_q | b_ovf_q;
      b_ovf_d = b_ovf_q | sum[16];
    end
  end

  // Moore outputs decoded from the state; data lines read zero outside RUN.
  always_comb begin
    req_ready   = 1'b0;
    out_valid   = 1'b0;
    out_data    = 16'd0;
    out_last    = 1'b0;
    out_ovf     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    dbg_state_o = state_q;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_RUN: begin
        out_valid = 1'b1;
        out_data  = a_q;
        out_last  = last_beat;
        out_ovf   = ovf_q;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Bench for fib_seq_ctrl: scenario tasks run in sequence, an expected-beat
// queue filled from a reference model, and a negedge monitor that pops and
// compares on every transfer and checks stability during stalls.
module tb_fib_seq_ctrl;

  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic             clk;
  logic             rst;
  logic             req_valid;
  logic [CNT_W-1:0] req_count;
  logic             req_ready;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             out_last;
  logic             out_ovf;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fib_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_count  (req_count),
    .req_ready  (req_ready),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ovf    (out_ovf),
    .busy       (busy),
    .done       (done),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];   // {data, last, ovf}
  int          checks;
  int          errors;
  logic        stall_pend;
  logic [17:0] held;
  logic        pat [4];

  // Reference model: data wraps mod 2^16, ovf follows the true value.
  task automatic push_model(input int n, input int n_push);
    logic [15:0] a, b, t;
    longint      ta, tb2, tt;
    logic        ovf;
    a = 16'd1; b = 16'd1; ta = 1; tb2 = 1; ovf = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (ta >= 65536) ovf = 1'b1;
      if (k <= n_push) exp_q.push_back({a, (k == n), ovf});
      t = a + b; a = b; b = t;
      if (!ovf) begin tt = ta + tb2; ta = tb2; tb2 = tt; end
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    logic [17:0] obs;
    logic [17:0] e;
    obs = {out_data, out_last, out_ovf};
    if (!rst && out_valid === 1'b1) begin
      if (stall_pend) begin
        checks++;
        if (obs !== held) begin
          errors++;
          $display("FAIL stall_stable: got %h required %h", obs, held);
        end
      end
      if (out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got data=%0d last=%0b ovf=%0b required no beat",
                   out_data, out_last, out_ovf);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL beat: got data=%0d last=%0b ovf=%0b required data=%0d last=%0b ovf=%0b",
                     obs[17:2], obs[1], obs[0], e[17:2], e[1], e[0]);
          end
        end
        stall_pend = 1'b0;
      end else begin
        stall_pend = 1'b1;
        held       = obs;
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Wait for IDLE, then present one request for a single cycle.
  task automatic start_job(input int n, input int n_push);
    int w;
    w = 0;
    while (req_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 100) begin
      checks++; errors++;
      $display("FAIL start_timeout: req_ready=%0b required 1", req_ready);
    end
    push_model(n, n_push);
    req_valid = 1'b1;
    req_count = CNT_W'(n);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Run until done pulses. mode 0: always ready, 1: random ready plus
  // ignored request noise, 2: fixed ready pattern.
  task automatic run_job(input int budget, input int mode);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < budget) begin
      case (mode)
        0:       out_ready = 1'b1;
        1: begin
          out_ready = 1'($urandom_range(0, 1));
          req_valid = busy ? 1'($urandom_range(0, 1)) : 1'b0;
          req_count = CNT_W'($urandom_range(0, 255));
        end
        default: out_ready = pat[n % 4];
      endcase
      @(posedge clk); #1; n++;
      if (done === 1'b1) seen = 1'b1;
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL job_done: got no done within %0d cycles required done pulse", budget);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL job_beats: got %0d beats missing required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({req_ready, out_valid, out_data, out_last, out_ovf, busy, done} !== {1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got rr=%0b ov=%0b d=%0d l=%0b o=%0b b=%0b dn=%0b required rr=1 rest 0",
               req_ready, out_valid, out_data, out_last, out_ovf, busy, done);
    end
  endtask

  task automatic test_basic();
    start_job(5, 5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL basic_throughput: cycle %0d got ov=%0b rr=%0b required ov=1 rr=0", i, out_valid, req_ready);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({done, out_valid, req_ready, busy} !== 4'b1001) begin
      errors++;
      $display("FAIL basic_done: got dn=%0b ov=%0b rr=%0b b=%0b required 1,0,0,1", done, out_valid, req_ready, busy);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, req_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL basic_idle: got dn=%0b rr=%0b b=%0b required 0,1,0", done, req_ready, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_beats: got %0d missing required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_stall();
    start_job(4, 4);
    run_job(100, 2);
  endtask

  task automatic test_ovf();
    start_job(26, 26);
    for (int k = 1; k <= 26; k++) begin
      if (k == 24) begin
        checks++;
        if (out_data !== 16'd46368 || out_ovf !== 1'b0) begin
          errors++;
          $display("FAIL ovf_t24: got %0d/%0b required 46368/0", out_data, out_ovf);
        end
      end
      if (k == 25) begin
        checks++;
        if (out_data !== 16'd9489 || out_ovf !== 1'b1) begin
          errors++;
          $display("FAIL ovf_t25: got %0d/%0b required 9489/1", out_data, out_ovf);
        end
      end
      if (k == 26) begin
        checks++;
        if (out_data !== 16'd55857 || out_ovf !== 1'b1 || out_last !== 1'b1) begin
          errors++;
          $display("FAIL ovf_t26: got %0d/%0b last=%0b required 55857/1 last=1", out_data, out_ovf, out_last);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ovf_done: got %0b required 1", done);
    end
    exp_q.delete();
  endtask

  task automatic test_zero();
    start_job(0, 0);
    checks++;
    if ({done, out_valid, req_ready, busy} !== 4'b1001) begin
      errors++;
      $display("FAIL zero_done: got dn=%0b ov=%0b rr=%0b b=%0b required 1,0,0,1", done, out_valid, req_ready, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready: got %0b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_count = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_second: got dn=%0b ov=%0b required 1,0", done, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    start_job(10, 3);
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    abort     = 1'b1;
    @(posedge clk); #1;
    abort     = 1'b0;
    out_ready = 1'b1;
    checks++;
    if ({out_valid, done, busy, req_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL abort_idle: got ov=%0b dn=%0b b=%0b rr=%0b required 0,0,0,1", out_valid, done, busy, req_ready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_beats: got %0d missing required 0", exp_q.size());
      exp_q.delete();
    end
    start_job(2, 2);
    run_job(20, 0);
    // abort on the final transfer must be ignored
    start_job(2, 2);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL abort_last: got done=%0b required 1", done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_last_beats: got %0d missing required 0", exp_q.size());
      exp_q.delete();
    end
    // abort while idle is harmless
    @(posedge clk); #1;
    abort = 1'b1;
    start_job(3, 3);
    abort = 1'b0;
    run_job(20, 0);
  endtask

  task automatic test_reset_mid();
    start_job(6, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst   = 1'b1;
    abort = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    abort = 1'b0;
    checks++;
    if ({req_ready, out_valid, out_data, out_last, out_ovf, busy, done} !== {1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got rr=%0b ov=%0b d=%0d l=%0b o=%0b b=%0b dn=%0b required rr=1 rest 0",
               req_ready, out_valid, out_data, out_last, out_ovf, busy, done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_beats: got %0d missing required 0", exp_q.size());
      exp_q.delete();
    end
    start_job(3, 3);
    run_job(20, 0);
  endtask

  task automatic test_max();
    start_job(255, 255);
    run_job(300, 0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++) begin
      start_job(int'($urandom_range(1, 40)), 41);
      run_job(400, 1);
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    checks = 0; errors = 0; stall_pend = 1'b0; held = '0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    rst = 1'b1; req_valid = 1'b0; req_count = '0; abort = 1'b0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_ovf();
    test_zero();
    test_abort();
    test_reset_mid();
    test_max();
    test_random();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
